// File: rtl/act_issue_sched.sv
// ---------------------------------------------------------------------------
// act_issue_sched
//
// Issue scheduler in front of the tanh/sigmoid CORDIC activation unit. A
// length-tagged vector is accepted one element per cycle from a valid/ready
// source. Tanh/sigmoid elements are driven into the unit. Bypass/ReLU elements
// are computed locally and carried down a matching delay line, so results
// leave in issue order. The unit's pipeline cannot stall, so each issue
// reserves an output FIFO slot up front. The scheduler only issues while
// (fifo_count + inflight) is below FIFO_DEPTH.
//
// Optional feature: define ACT_SAT_CLAMP_EN to saturate tanh/sigmoid operands
// to [-SAT_LIMIT, +SAT_LIMIT] before they reach the unit. This keeps the
// unit's exp stage from overflowing. Bypass and ReLU are never clamped.
//
// Ports:
//   sys_clk, sys_rst_n    clock, asynchronous active-low reset
//   start                 one-cycle start pulse, accepted only when idle
//   cfg_mode, cfg_len     10 tanh, 01 sigmoid, 00 bypass, 11 ReLU; element count
//   busy, done            busy in RUN/DRAIN; done pulses after the last accept
//   in_data/valid/ready   operand stream
//   act_x, act_algorithm  operand and algorithm driven into the unit
//   act_rho               result from the unit, PIPE_LATENCY after act_x
//   out_data/valid/ready  result stream from the output FIFO
// ---------------------------------------------------------------------------
module act_issue_sched #(
    parameter int DATA_WIDTH   = 32,
    parameter int FRAC_WIDTH   = 16,
    parameter int PIPE_LATENCY = 28,
    parameter int FIFO_DEPTH   = 16,
    parameter logic [DATA_WIDTH-1:0] SAT_LIMIT = DATA_WIDTH'(8) << FRAC_WIDTH
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  start,
    input  logic [1:0]            cfg_mode,
    input  logic [15:0]           cfg_len,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] act_x,
    output logic [1:0]            act_algorithm,
    input  logic [DATA_WIDTH-1:0] act_rho,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [1:0] MODE_SIGMOID = 2'b01;
    localparam logic [1:0] MODE_TANH    = 2'b10;
    localparam logic [1:0] MODE_RELU    = 2'b11;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    localparam logic signed [DATA_WIDTH-1:0] SAT_POS = SAT_LIMIT;
    localparam logic signed [DATA_WIDTH-1:0] SAT_NEG = -SAT_LIMIT;

`ifdef ACT_SAT_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    logic [1:0]      mode_q;
    logic [15:0]     len_q;
    logic [15:0]     issued;
    logic [15:0]     accepted;

    logic            issue;
    logic            out_fire;
    logic            uses_unit;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   fifo_count;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW:0]     credit_used;

    logic [DATA_WIDTH-1:0] clamped_x;
    logic [DATA_WIDTH-1:0] unit_x;
    logic [DATA_WIDTH-1:0] local_x;

    logic [PIPE_LATENCY:0]  dly_vld;
    logic [PIPE_LATENCY:0]  dly_unit;
    logic [DATA_WIDTH-1:0]  dly_data [0:PIPE_LATENCY];

    logic                   fifo_wr;
    logic [DATA_WIDTH-1:0]  fifo_wdata;
    logic [DATA_WIDTH-1:0]  fifo_mem [0:FIFO_DEPTH-1];

    // A slot is reserved per issue. Every element in flight is guaranteed a
    // FIFO entry when it reaches the tail of the delay line.
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
    assign in_ready    = (state == S_RUN) && (issued < len_q) && (credit_used < DEPTH_C);
    assign issue       = in_valid && in_ready;
    assign out_valid   = (fifo_count != '0);
    assign out_fire    = out_valid && out_ready;
    assign out_data    = out_valid ? fifo_mem[rd_ptr] : '0;
    assign uses_unit   = (mode_q == MODE_TANH) || (mode_q == MODE_SIGMOID);

    assign fifo_wr     = dly_vld[PIPE_LATENCY];
    assign fifo_wdata  = dly_unit[PIPE_LATENCY] ? act_rho : dly_data[PIPE_LATENCY];

    // Saturate the operand for the unit. The clamp is always computed; the
    // build-time switch decides whether the unit actually sees it.
    always_comb begin
        clamped_x = in_data;
        if ($signed(in_data) > SAT_POS) begin
            clamped_x = SAT_POS;
        end else if ($signed(in_data) < SAT_NEG) begin
            clamped_x = SAT_NEG;
        end
    end

    assign unit_x  = CLAMP_EN ? clamped_x : in_data;
    assign local_x = ((mode_q == MODE_RELU) && in_data[DATA_WIDTH-1]) ? '0 : in_data;

    // Control FSM. The transition into DONE from DRAIN raises done on the same
    // edge as the last accept, so done follows that handshake by one cycle.
    // The zero-length path enters DONE with done still low, and DONE toggles
    // it. This produces a single pulse one cycle later in either case.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= S_IDLE;
            mode_q   <= '0;
            len_q    <= '0;
            issued   <= '0;
            accepted <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mode_q   <= cfg_mode;
                        len_q    <= cfg_len;
                        issued   <= '0;
                        accepted <= '0;
                        if (cfg_len == 16'd0) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        issued <= issued + 16'd1;
                        if (issued + 16'd1 == len_q) begin
                            state <= S_DRAIN;
                        end
                    end
                    if (out_fire) begin
                        accepted <= accepted + 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (out_fire) begin
                        accepted <= accepted + 16'd1;
                        if (accepted + 16'd1 == len_q) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done  <= ~done;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Unit operand register. The unit sees zeros whenever nothing is being
    // issued to it. This includes cycles that issue bypass/ReLU elements.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            act_x         <= '0;
            act_algorithm <= 2'b00;
        end else if (issue && uses_unit) begin
            act_x         <= unit_x;
            act_algorithm <= mode_q;
        end else begin
            act_x         <= '0;
            act_algorithm <= 2'b00;
        end
    end

    // Latency-matched delay line. Stage 0 lines up with act_x, and stage
    // PIPE_LATENCY lines up with the matching act_rho. Clearing the valids
    // on reset drops any unit results still in flight.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dly_vld  <= '0;
            dly_unit <= '0;
            for (int i = 0; i <= PIPE_LATENCY; i++) begin
                dly_data[i] <= '0;
            end
        end else begin
            dly_vld     <= {dly_vld[PIPE_LATENCY-1:0], issue};
            dly_unit    <= {dly_unit[PIPE_LATENCY-1:0], uses_unit};
            dly_data[0] <= local_x;
            for (int i = 1; i <= PIPE_LATENCY; i++) begin
                dly_data[i] <= dly_data[i-1];
            end
        end
    end

    // Count of elements between issue and FIFO write. It is added to
    // fifo_count to form the credit check.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            inflight <= '0;
        end else begin
            case ({issue, fifo_wr})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // FIFO pointers and occupancy. Writing while full cannot happen because
    // of the credit check. A read needs out_valid, so a write into an empty
    // FIFO always simply becomes visible on the next cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (out_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({fifo_wr, out_fire})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage. It has no reset because out_data is masked while the
    // FIFO is empty.
    always_ff @(posedge sys_clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr] <= fifo_wdata;
        end
    end

endmodule

// File: tb/tb_act_issue_sched.sv
// ---------------------------------------------------------------------------
// tb_act_issue_sched
//
// Bench for act_issue_sched. The activation unit is stood in for by a fixed
// PIPE_LATENCY delay that returns x+1. A reference model turns each issued
// operand into its expected result and queues it in issue order. A negedge
// monitor checks every result and every act_x/act_algorithm cycle against
// that model. Directed vectors, multi-cycle corner cases and randomized runs
// drive the DUT. Honours ACT_SAT_CLAMP_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_act_issue_sched;

    localparam int PL    = 28;
    localparam int DEPTH = 16;
    localparam int LIMIT = 600;
    localparam int NV    = 10;

    localparam logic [1:0] M_BYP  = 2'b00;
    localparam logic [1:0] M_SIG  = 2'b01;
    localparam logic [1:0] M_TANH = 2'b10;
    localparam logic [1:0] M_RELU = 2'b11;

`ifdef ACT_SAT_CLAMP_EN
    localparam logic [31:0] ACTX_P16 = 32'h0008_0000;
    localparam logic [31:0] ACTX_N16 = 32'hFFF8_0000;
`else
    localparam logic [31:0] ACTX_P16 = 32'h0010_0000;
    localparam logic [31:0] ACTX_N16 = 32'hFFF0_0000;
`endif

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] x;
        logic [31:0] exp_out;
        logic [31:0] exp_actx;
        logic [1:0]  exp_alg;
    } vec_t;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        start;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_len;
    logic        busy;
    logic        done;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] act_x;
    logic [1:0]  act_algorithm;
    logic [31:0] act_rho;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int          total = 0;
    int          bad   = 0;
    logic [1:0]  cur_mode = M_BYP;
    logic [31:0] exp_q [$];
    logic [31:0] vals [0:63];
    logic [31:0] upipe [0:PL-1];
    vec_t        vecs [NV];

    logic        pend = 1'b0;
    logic [31:0] pend_x = '0;
    logic [1:0]  pend_alg = '0;

    logic [31:0] cap_out;
    logic [31:0] cap_actx;
    logic [1:0]  cap_alg;
    int          fi;
    int          fo;

    act_issue_sched dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .start         (start),
        .cfg_mode      (cfg_mode),
        .cfg_len       (cfg_len),
        .busy          (busy),
        .done          (done),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .act_x         (act_x),
        .act_algorithm (act_algorithm),
        .act_rho       (act_rho),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Stand-in activation unit: returns x+1 exactly PL cycles after act_x.
    always @(posedge sys_clk) begin
        upipe[0] <= act_x + 32'd1;
        for (int k = 1; k < PL; k++) begin
            upipe[k] <= upipe[k-1];
        end
    end
    assign act_rho = upipe[PL-1];

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] clampModel(input logic [31:0] x);
        int sx;
        sx = $signed(x);
`ifdef ACT_SAT_CLAMP_EN
        if (sx > 524288) return 32'h0008_0000;
        if (sx < -524288) return 32'hFFF8_0000;
`endif
        return x;
    endfunction

    function automatic logic [31:0] expectedOut(input logic [1:0] mode, input logic [31:0] x);
        int sx;
        sx = $signed(x);
        if (mode == M_TANH || mode == M_SIG) return clampModel(x) + 32'd1;
        if (mode == M_RELU) return (sx < 0) ? 32'd0 : x;
        return x;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'b0, done}, 32'd0);
        checkOutput({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
        checkOutput({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        checkOutput({tag, "_out_data"}, out_data, 32'd0);
        checkOutput({tag, "_act_x"}, act_x, 32'd0);
        checkOutput({tag, "_act_alg"}, {30'b0, act_algorithm}, 32'd0);
    endtask

    // Monitor: checks the unit-side operand one cycle after each issue, queues
    // the expected result for each issue, and checks each accepted output in order.
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            exp_q.delete();
            pend = 1'b0;
        end else begin
            if (pend) begin
                checkOutput("act_x", act_x, pend_x);
                checkOutput("act_algorithm", {30'b0, act_algorithm}, {30'b0, pend_alg});
            end else begin
                checkOutput("act_x_idle", act_x, 32'd0);
                checkOutput("act_alg_idle", {30'b0, act_algorithm}, 32'd0);
            end
            pend = in_valid && in_ready;
            if (pend) begin
                if (cur_mode == M_TANH || cur_mode == M_SIG) begin
                    pend_x   = clampModel(in_data);
                    pend_alg = cur_mode;
                end else begin
                    pend_x   = 32'd0;
                    pend_alg = 2'b00;
                end
                exp_q.push_back(expectedOut(cur_mode, in_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_out", {31'b0, out_valid}, 32'd0);
                end else begin
                    checkOutput("out_data", out_data, exp_q.pop_front());
                end
            end
        end
    end

    // Runs one vector of len elements from vals[].
    // policy 0: always ready. policy 1: out_ready held low for hold cycles.
    // policy 2: random valid/ready plus stray start pulses.
    task automatic applyStimulus(input logic [1:0] mode, input int len, input int policy, input int hold);
        int idx;
        int acc;
        int cyc;
        bit iss;
        bit fire;
        bit got_done;
        idx = 0; acc = 0; cyc = 0; got_done = 0;
        fi = -1; fo = -1;
        cur_mode = mode;
        cfg_mode = mode;
        cfg_len  = 16'(len);
        start    = 1'b1;
        @(posedge sys_clk); #1;
        start    = 1'b0;
        cfg_mode = ~mode;
        cfg_len  = 16'hFFFF;
        checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
        checkOutput("ready_after_start", {31'b0, in_ready}, 32'd1);
        while (!got_done && cyc < LIMIT) begin
            if (policy == 1 && cyc == hold) begin
                checkOutput("bp_issued", idx, DEPTH);
                checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
            end
            case (policy)
                0: begin
                    out_ready = 1'b1;
                    in_valid  = (idx < len);
                end
                1: begin
                    out_ready = (cyc >= hold);
                    in_valid  = (idx < len);
                end
                default: begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    in_valid  = (idx < len) && ($urandom_range(0, 3) != 0);
                    start     = ($urandom_range(0, 15) == 0);
                    cfg_len   = 16'($urandom_range(0, 20));
                    cfg_mode  = 2'($urandom_range(0, 3));
                end
            endcase
            in_data = (idx < len) ? vals[idx] : 32'd0;
            iss  = in_valid && in_ready;
            fire = out_valid && out_ready;
            if (iss && idx == 0) fi = cyc;
            if (fire) cap_out = out_data;
            @(posedge sys_clk); #1;
            cyc++;
            if (iss) begin
                idx++;
                cap_actx = act_x;
                cap_alg  = act_algorithm;
            end
            if (fo < 0 && out_valid) fo = cyc;
            if (fire) begin
                acc++;
                if (acc == len) begin
                    checkOutput("done_after_last", {31'b0, done}, 32'd1);
                    checkOutput("busy_fall", {31'b0, busy}, 32'd0);
                end
            end
            if (done) begin
                got_done = 1'b1;
                checkOutput("done_count", acc, len);
            end
        end
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        if (!got_done) checkOutput("done_timeout", 32'd0, 32'd1);
        @(posedge sys_clk); #1;
        checkOutput("done_pulse", {31'b0, done}, 32'd0);
        checkOutput("model_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        int n;
        int guard;
        bit iss;

        sys_rst_n = 1'b0;
        start     = 1'b0;
        cfg_mode  = 2'b00;
        cfg_len   = 16'd0;
        in_data   = 32'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{M_RELU, 32'hFFFE_8000, 32'h0000_0000, 32'h0, 2'b00};
        vecs[1] = '{M_RELU, 32'h0002_0000, 32'h0002_0000, 32'h0, 2'b00};
        vecs[2] = '{M_RELU, 32'h8000_0000, 32'h0000_0000, 32'h0, 2'b00};
        vecs[3] = '{M_RELU, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, 2'b00};
        vecs[4] = '{M_BYP,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 2'b00};
        vecs[5] = '{M_BYP,  32'h0000_0000, 32'h0000_0000, 32'h0, 2'b00};
        vecs[6] = '{M_TANH, 32'h0010_0000, ACTX_P16 + 32'd1, ACTX_P16, M_TANH};
        vecs[7] = '{M_TANH, 32'hFFF0_0000, ACTX_N16 + 32'd1, ACTX_N16, M_TANH};
        vecs[8] = '{M_SIG,  32'h0008_0000, 32'h0008_0001, 32'h0008_0000, M_SIG};
        vecs[9] = '{M_SIG,  32'h0000_1234, 32'h0000_1235, 32'h0000_1234, M_SIG};

        repeat (3) @(posedge sys_clk);
        #1;
        checkResetValues("reset");
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        $display("[TB] directed vectors");
        for (int i = 0; i < NV; i++) begin
            vals[0] = vecs[i].x;
            applyStimulus(vecs[i].mode, 1, 0, 0);
            checkOutput("vec_out", cap_out, vecs[i].exp_out);
            checkOutput("vec_act_x", cap_actx, vecs[i].exp_actx);
            checkOutput("vec_alg", {30'b0, cap_alg}, {30'b0, vecs[i].exp_alg});
        end

        $display("[TB] tanh len=4 latency");
        vals[0] = 32'h0001_0000;
        vals[1] = 32'hFFFF_0000;
        vals[2] = 32'h0000_4000;
        vals[3] = 32'h0000_0000;
        applyStimulus(M_TANH, 4, 0, 0);
        checkOutput("first_out_latency", fo - fi, PL + 2);

        $display("[TB] sigmoid len=40 backpressure");
        for (int i = 0; i < 40; i++) vals[i] = 32'($urandom_range(0, 32'h000F_FFFF)) - 32'h0008_0000;
        applyStimulus(M_SIG, 40, 1, 80);

        $display("[TB] zero length");
        cfg_mode = M_TANH;
        cfg_len  = 16'd0;
        start    = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        checkOutput("len0_busy_t1", {31'b0, busy}, 32'd0);
        checkOutput("len0_done_t1", {31'b0, done}, 32'd0);
        @(posedge sys_clk); #1;
        checkOutput("len0_done_t2", {31'b0, done}, 32'd1);
        checkOutput("len0_busy_t2", {31'b0, busy}, 32'd0);
        @(posedge sys_clk); #1;
        checkOutput("len0_done_t3", {31'b0, done}, 32'd0);

        $display("[TB] reset mid-run");
        for (int i = 0; i < 8; i++) vals[i] = 32'h0000_0100 * 32'(i + 1);
        cur_mode  = M_TANH;
        cfg_mode  = M_TANH;
        cfg_len   = 16'd8;
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        n = 0;
        guard = 0;
        while (n < 3 && guard < 20) begin
            in_valid = 1'b1;
            in_data  = vals[n];
            iss = in_ready;
            @(posedge sys_clk); #1;
            if (iss) n++;
            guard++;
        end
        in_valid = 1'b0;
        checkOutput("pre_rst_issued", n, 32'd3);
        #2;
        sys_rst_n = 1'b0;
        #1;
        checkResetValues("midrst");
        repeat (5) begin
            @(posedge sys_clk); #1;
            checkOutput("rst_hold_busy", {31'b0, busy}, 32'd0);
            checkOutput("rst_hold_out_valid", {31'b0, out_valid}, 32'd0);
        end
        sys_rst_n = 1'b1;
        repeat (40) begin
            @(posedge sys_clk); #1;
            checkOutput("no_out_after_rst", {31'b0, out_valid}, 32'd0);
        end
        applyStimulus(M_TANH, 4, 0, 0);

        $display("[TB] randomized runs");
        for (int r = 0; r < 25; r++) begin
            int len;
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 3))
                    0: vals[i] = $urandom;
                    1: vals[i] = 32'($urandom_range(0, 32'h001F_FFFF)) - 32'h0010_0000;
                    2: begin
                        case ($urandom_range(0, 3))
                            0: vals[i] = 32'h0008_0000;
                            1: vals[i] = 32'hFFF8_0000;
                            2: vals[i] = 32'h0008_0001;
                            default: vals[i] = 32'hFFF7_FFFF;
                        endcase
                    end
                    default: vals[i] = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                endcase
            end
            applyStimulus(2'($urandom_range(0, 3)), len, 2, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
